// File: rtl/decoder_n_seq.sv
// decoder_n_seq: registered N-to-2**N one-hot decoder with three behaviours selected
// at acceptance time: DIRECT (hold until next accept), PULSE (hold for PULSE_LEN
// cycles, then clear) and SCAN (walk the hot bit upward while en stays high).
module decoder_n_seq #(
  parameter int unsigned N         = 3,
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [N-1:0]          din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [(1<<N)-1:0]     y,
  output logic                  y_valid,
  output logic                  scan_wrap
);

  localparam int unsigned W = 1 << N;

  localparam logic [1:0] ModePulse = 2'd1;
  localparam logic [1:0] ModeScan  = 2'd2;

  localparam logic [7:0] PulseCnt = 8'(PULSE_LEN);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StScan
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [N-1:0]   idx_inc;
  logic [7:0]     cnt_q, cnt_d;
  logic [W-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;
  logic           scan_wrap_q, scan_wrap_d;
  logic           accept;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Ready is gated by rst_n so it reads 0 for the whole reset interval.
  always_comb begin
    din_ready = rst_n & en & (state_q == StIdle);
    accept    = din_valid & din_ready;
    idx_inc   = idx_q + 1'b1;
  end

  // Next-state and registered-output logic; mode only matters on acceptance.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    y_valid_d   = 1'b0;
    scan_wrap_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          y_d       = onehot(din);
          y_valid_d = 1'b1;
          idx_d     = din;
          case (mode)
            ModePulse: begin
              state_d = StHold;
              cnt_d   = PulseCnt;
            end
            ModeScan: begin
              state_d = StScan;
            end
            // DIRECT and the reserved encoding stay in idle.
            default: ;
          endcase
        end
      end
      StHold: begin
        // Counter holds the number of held cycles still to be shown, this one included.
        if (cnt_q <= 8'd1) begin
          y_d     = '0;
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StScan: begin
        if (en) begin
          idx_d       = idx_inc;
          y_d         = onehot(idx_inc);
          y_valid_d   = 1'b1;
          scan_wrap_d = (idx_q == {N{1'b1}});
        end else begin
          y_d     = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        y_d     = '0;
      end
    endcase
  end

  // State register with asynchronous clear of every output and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= 8'd0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// Self-checking bench for decoder_n_seq (N=3, PULSE_LEN=4): each driven cycle queues the
// expected din_ready for that cycle and the expected outputs after the next edge.
module tb_decoder_n_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [2:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] y;
  logic       y_valid;
  logic       scan_wrap;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  typedef struct {
    int         cyc;
    logic       is_out;
    logic       rdy;
    logic [7:0] y;
    logic       yv;
    logic       w;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  decoder_n_seq #(
    .N         (3),
    .PULSE_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .y         (y),
    .y_valid   (y_valid),
    .scan_wrap (scan_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", tag, cyc_cnt, act, exp);
    end
  endtask

  // Drive one cycle of stimulus; er is din_ready now, ey/eyv/ew the outputs after the edge.
  task automatic step(input logic e, input logic [1:0] m, input logic [2:0] d, input logic v,
                      input logic er, input logic [7:0] ey, input logic eyv, input logic ew);
    exp_t r;
    en        = e;
    mode      = m;
    din       = d;
    din_valid = v;
    r.cyc    = cyc_cnt;
    r.is_out = 1'b0;
    r.rdy    = er;
    r.y      = 8'h00;
    r.yv     = 1'b0;
    r.w      = 1'b0;
    q.push_back(r);
    r.cyc    = cyc_cnt + 1;
    r.is_out = 1'b1;
    r.y      = ey;
    r.yv     = eyv;
    r.w      = ew;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one edge starting mid-cycle; outputs must clear at once.
  task automatic pulse_reset(input logic [7:0] y_before);
    check_eq("pre_rst_y", 64'(y), 64'(y_before));
    rst_n = 1'b0;
    #1;
    check_eq("rst_y_async", 64'(y), 64'h0);
    check_eq("rst_yv_async", 64'(y_valid), 64'h0);
    check_eq("rst_ready_async", 64'(din_ready), 64'h0);
    while (q.size() > 0 && q[0].cyc == cyc_cnt) void'(q.pop_front());
    @(posedge clk);
    #1;
    check_eq("rst_y_held", 64'(y), 64'h0);
    check_eq("rst_wrap_held", 64'(scan_wrap), 64'h0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare every entry due at this falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc_cnt) begin
          check_eq("sb_stale", 64'(mon_e.cyc), 64'(cyc_cnt));
        end else if (mon_e.is_out) begin
          check_eq("y", 64'(y), 64'(mon_e.y));
          check_eq("y_valid", 64'(y_valid), 64'(mon_e.yv));
          check_eq("scan_wrap", 64'(scan_wrap), 64'(mon_e.w));
          check_eq("onehot", 64'($countones(y) <= 1), 64'h1);
        end else begin
          check_eq("din_ready", 64'(din_ready), 64'(mon_e.rdy));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    mode      = 2'd0;
    din       = 3'd0;
    din_valid = 1'b0;
    #2;
    check_eq("reset_y", 64'(y), 64'h0);
    check_eq("reset_y_valid", 64'(y_valid), 64'h0);
    check_eq("reset_wrap", 64'(scan_wrap), 64'h0);
    check_eq("reset_ready", 64'(din_ready), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First cycle after release with en=1: ready.
    step(1, 0, 0, 0, 1, 8'h00, 0, 0);

    // DIRECT din=5, then hold.
    step(1, 0, 5, 1, 1, 8'h20, 1, 0);
    step(1, 0, 0, 0, 1, 8'h20, 0, 0);
    step(1, 2, 3, 0, 1, 8'h20, 0, 0);

    // DIRECT back-to-back 0 then 7.
    step(1, 0, 0, 1, 1, 8'h01, 1, 0);
    step(1, 0, 7, 1, 1, 8'h80, 1, 0);
    step(1, 0, 0, 0, 1, 8'h80, 0, 0);

    // PULSE din=2: four held cycles, din_valid in HOLD ignored, en low ignored.
    step(1, 1, 2, 1, 1, 8'h04, 1, 0);
    step(1, 1, 5, 1, 0, 8'h04, 0, 0);
    step(1, 0, 5, 1, 0, 8'h04, 0, 0);
    step(0, 0, 0, 0, 0, 8'h04, 0, 0);
    step(1, 0, 3, 1, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 1, 8'h00, 0, 0);

    // SCAN din=6 with wrap, then drop en.
    step(1, 2, 6, 1, 1, 8'h40, 1, 0);
    step(1, 0, 0, 0, 0, 8'h80, 1, 0);
    step(1, 0, 0, 0, 0, 8'h01, 1, 1);
    step(1, 0, 0, 0, 0, 8'h02, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 1, 8'h00, 0, 0);

    // en has priority over din_valid.
    step(0, 0, 4, 1, 0, 8'h00, 0, 0);

    // Reset in cycle 2 of a PULSE hold.
    step(1, 1, 2, 1, 1, 8'h04, 1, 0);
    step(1, 0, 0, 0, 0, 8'h04, 0, 0);
    pulse_reset(8'h04);
    step(1, 0, 0, 0, 1, 8'h00, 0, 0);
    step(1, 0, 0, 0, 1, 8'h00, 0, 0);

    // Mode changed during HOLD has no effect; next accept uses the new mode.
    step(1, 1, 1, 1, 1, 8'h02, 1, 0);
    step(1, 2, 1, 0, 0, 8'h02, 0, 0);
    step(1, 2, 0, 0, 0, 8'h02, 0, 0);
    step(1, 2, 0, 0, 0, 8'h02, 0, 0);
    step(1, 2, 0, 0, 0, 8'h00, 0, 0);
    step(1, 2, 3, 1, 1, 8'h08, 1, 0);
    step(0, 0, 0, 0, 0, 8'h00, 0, 0);

    // Reserved mode 3 behaves as DIRECT.
    step(1, 3, 4, 1, 1, 8'h10, 1, 0);
    step(1, 1, 0, 0, 1, 8'h10, 0, 0);
    step(1, 0, 0, 0, 1, 8'h10, 0, 0);

    @(negedge clk);
    #1;
    check_eq("sb_drained", 64'(q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 The block SHALL take parameter N, default 3, as the select width; the output width is 2**N, and N SHALL be in the range 1..6.
REQ-002 The block SHALL take parameter PULSE_LEN, default 4, as the number of cycles an output is held in PULSE mode; PULSE_LEN SHALL be in the range 1..255.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  global enable; gates acceptance of input and SCAN stepping.
REQ-006 mode  input  2  operating mode: 0=DIRECT, 1=PULSE, 2=SCAN, 3=reserved (treated as DIRECT).
REQ-007 din  input  N  select index.
REQ-008 din_valid  input  1  din is valid this cycle.
REQ-009 din_ready  output  1  block can accept din this cycle.
REQ-010 y  output  2**N  registered one-hot decoded output (or all-zero).
REQ-011 y_valid  output  1  one-cycle pulse, asserted in the first cycle a new y value is presented.
REQ-012 scan_wrap  output  1  one-cycle pulse, asserted when SCAN wraps from index 2**N-1 to index 0.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, HOLD and SCAN.
REQ-014 din_ready SHALL be 1 only when the FSM is in IDLE and en=1; acceptance SHALL be din_valid && din_ready.
REQ-015 mode SHALL be sampled only at acceptance; changes to mode at any other time SHALL have no effect until the next acceptance.
REQ-016 y SHALL never have more than one bit set in any cycle.
REQ-017 DIRECT mode: on acceptance at edge k, y SHALL equal 1<<din and y_valid SHALL be 1 after edge k (latency 1).
- The FSM SHALL stay in IDLE.
- y SHALL hold its value until the next acceptance.
- Back-to-back acceptances on consecutive cycles SHALL be supported.
REQ-018 PULSE mode: on acceptance, the block SHALL drive y=1<<din from the next cycle for exactly PULSE_LEN cycles and SHALL pulse y_valid in the first of those cycles.
- The FSM SHALL move to HOLD, with din_ready=0 for the duration.
- After the last held cycle, y SHALL become 0 and the FSM SHALL return to IDLE.
- An internal 8-bit down-counter SHALL count the held cycles.
- The hold SHALL continue regardless of en.
REQ-019 SCAN mode: on acceptance, the block SHALL drive y=1<<din from the next cycle and the FSM SHALL move to SCAN.
- Each cycle in SCAN with en=1, the index SHALL increment by 1 modulo 2**N.
- y_valid SHALL pulse on each index change.
- With en=0 in SCAN, the block SHALL clear y to 0 on the next edge and return to IDLE.
REQ-020 On the SCAN step from index 2**N-1 to 0, scan_wrap SHALL be 1 in the cycle y shows bit 0.
REQ-021 When en and din_valid change in the same cycle, en SHALL take priority: with en=0, nothing is accepted and no stepping occurs.
REQ-022 In IDLE with no acceptance, y SHALL keep its value and y_valid and scan_wrap SHALL be 0.

Reset
REQ-023 While rst_n=0, the block SHALL force y=0, y_valid=0, scan_wrap=0, din_ready=0, FSM=IDLE and counter=0, asynchronously, in any state including mid-HOLD and mid-SCAN.
REQ-024 After rst_n deasserts, din_ready SHALL be 1 in the first cycle in which en=1.
REQ-025 Reset SHALL discard any in-progress PULSE or SCAN operation, with no residual output.

Verification
REQ-026 The bench SHALL cover each of the following directed scenarios:
- N=3, DIRECT, din=5 accepted -> next cycle y=8'b0010_0000 and y_valid=1; the cycle after, y_valid=0 and y unchanged.
- DIRECT back-to-back din=0 then din=7 -> y=8'h01 then y=8'h80 on consecutive cycles, with y_valid high in both.
- PULSE_LEN=4, PULSE, din=2 -> y=8'h04 for exactly 4 cycles, then 0; din_ready=0 for those 4 cycles; din_valid asserted during HOLD is ignored.
- SCAN, din=6, en held high 4 cycles -> y=8'h40, 8'h80, 8'h01, 8'h02; scan_wrap=1 only with 8'h01; dropping en -> y=0 next cycle, FSM returns to IDLE.
- rst_n pulsed low mid-PULSE (cycle 2 of 4) -> y=0 immediately; din_ready=1 on the first clock after release with en=1.
- mode changed 1->2 during HOLD -> no effect; the next acceptance uses the new mode; mode=3 behaves as DIRECT.
